// File: rtl/aes_ahb_pkg.sv
// Shared AHB-Lite constants, command/status/state encodings and the
// register-offset helper used by the AES slave-port initiator.
package aes_ahb_pkg;

    localparam logic [1:0]  HTRANS_IDLE     = 2'b00;
    localparam logic [1:0]  HTRANS_NONSEQ   = 2'b10;
    localparam logic [2:0]  HSIZE_128       = 3'b100;
    localparam logic [2:0]  HBURST_SINGLE   = 3'b000;
    localparam logic [3:0]  HPROT_DATA_PRIV = 4'b0011;

    localparam logic [31:0] KEY_OFS    = 32'h0000_0000;
    localparam logic [31:0] DATA_OFS   = 32'h0000_0010;
    localparam logic [31:0] RESULT_OFS = 32'h0000_0020;

    typedef enum logic [1:0] {
        WRITE_KEY   = 2'b00,
        WRITE_DATA  = 2'b01,
        READ_RESULT = 2'b10,
        OP_BAD      = 2'b11
    } aes_op_t;

    typedef enum logic [1:0] {
        OK      = 2'b00,
        BUS_ERR = 2'b01,
        TIMEOUT = 2'b10,
        BAD_OP  = 2'b11
    } rsp_status_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADDR = 2'b01,
        DATA = 2'b10,
        RESP = 2'b11
    } state_t;

    function automatic logic [31:0] op_offset(input aes_op_t op);
        case (op)
            WRITE_KEY:  return KEY_OFS;
            WRITE_DATA: return DATA_OFS;
            default:    return RESULT_OFS;
        endcase
    endfunction

endpackage

// File: rtl/ahb_wait_timer.sv
// Saturating wait-state counter; expired flags the increment that reaches LIMIT.
// LIMIT of zero disables expiry altogether.
module ahb_wait_timer #(
    parameter int unsigned LIMIT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int unsigned W    = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
    localparam logic [W-1:0] MAX  = W'(LIMIT);
    localparam logic [W-1:0] LAST = (LIMIT > 0) ? W'(LIMIT - 1) : '0;

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (LIMIT != 0) && inc && (count_q == LAST);

endmodule

// File: rtl/aes_ahb_master.sv
// AHB-Lite single-transfer initiator for the AES accelerator slave port:
// one valid/ready command in, one NONSEQ/SINGLE transfer, one response pulse out.
module aes_ahb_master
    import aes_ahb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [127:0] cmd_wdata,
    output logic         rsp_valid,
    output logic [1:0]   rsp_status,
    output logic [127:0] rsp_rdata,
    output logic [31:0]  HADDR,
    output logic [2:0]   HBURST,
    output logic         HMASTLOCK,
    output logic [3:0]   HPORT,
    output logic [2:0]   HSIZE,
    output logic [1:0]   HTRANS,
    output logic         HWRITE,
    output logic         HSELx,
    output logic [127:0] HWDATA,
    input  logic         HREADY,
    input  logic         HRESP,
    input  logic [127:0] HRDATA
);

    state_t      state_q, state_d;
    aes_op_t     op_q, op_d;
    logic [127:0] wdata_q, wdata_d;
    rsp_status_t status_q, status_d;
    logic [127:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        timer_clr, timer_inc, timer_expired;

    ahb_wait_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clr),
        .inc     (timer_inc),
        .expired (timer_expired)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        wdata_d   = wdata_q;
        status_d  = status_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        timer_clr = 1'b0;
        timer_inc = 1'b0;
        case (state_q)
            IDLE: begin
                timer_clr = 1'b1;
                if (cmd_valid) begin
                    op_d    = aes_op_t'(cmd_op);
                    wdata_d = cmd_wdata;
                    if (aes_op_t'(cmd_op) == OP_BAD) begin
                        status_d = BAD_OP;
                        state_d  = RESP;
                    end else begin
                        state_d = ADDR;
                    end
                end
            end
            ADDR: begin
                if (HREADY) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                // An error seen on the first (wait) cycle must survive to the completing cycle.
                if (HRESP) begin
                    err_d = 1'b1;
                end
                if (HREADY) begin
                    if (HRESP || err_q) begin
                        status_d = BUS_ERR;
                    end else begin
                        status_d = OK;
                        if (op_q == READ_RESULT) begin
                            rdata_d = HRDATA;
                        end
                    end
                    state_d = RESP;
                end else begin
                    timer_inc = 1'b1;
                    if (timer_expired) begin
                        status_d = TIMEOUT;
                        state_d  = RESP;
                    end
                end
            end
            RESP: begin
                timer_clr = 1'b1;
                err_d     = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= WRITE_KEY;
            wdata_q  <= '0;
            status_q <= OK;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            wdata_q  <= wdata_d;
            status_q <= status_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Bus outputs decode only from registered state, so they never glitch on inputs.
    assign HTRANS     = (state_q == ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HSELx      = (state_q == ADDR) || (state_q == DATA);
    assign HADDR      = (state_q == ADDR) ? (BASE_ADDR + op_offset(op_q)) : 32'h0;
    assign HWRITE     = (state_q == ADDR) && (op_q != READ_RESULT);
    assign HWDATA     = (state_q == DATA) ? wdata_q : 128'h0;
    assign HBURST     = HBURST_SINGLE;
    assign HMASTLOCK  = 1'b0;
    assign HPORT      = HPROT_DATA_PRIV;
    assign HSIZE      = HSIZE_128;

    assign cmd_ready  = (state_q == IDLE) && !rst;
    assign rsp_valid  = (state_q == RESP);
    assign rsp_status = status_q;
    assign rsp_rdata  = rdata_q;

endmodule
